hex_display_arbiter: RTL

- Shares one 7-segment digit between four requesters (switch nibbles, counters, status sources) using round-robin arbitration with a minimum on-screen hold time.
- Drives a second digit with the index of the current owner.
- Sits between the board top level and the HEX0/HEX1 outputs, and replaces the direct nibble-to-display connection.
- Segment outputs are active-low (0 = segment on), with full 0-F decoding.

---
 rtl/hex_display_arbiter_if.sv | 21 ++
 rtl/hex_display_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/hex_display_arbiter_if.sv
// Request/data and display bundle between the board top level and the shared
// HEX0/HEX1 arbiter; master drives requests, slave is the arbiter.
interface hex_display_arbiter_if;
  logic [3:0]  req;
  logic [15:0] data;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  cur_digit;
  logic [6:0]  hex_digit;
  logic [6:0]  hex_owner;

  modport master (
    output req, data,
    input  grant, busy, cur_digit, hex_digit, hex_owner
  );

  modport slave (
    input  req, data,
    output grant, busy, cur_digit, hex_digit, hex_owner
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of one 7-segment digit among four requesters, with a
// minimum hold time; a second digit shows the owner index. All outputs registered.
module hex_display_arbiter #(
  parameter int HOLD_CYCLES = 25000000,
  parameter int CNT_W       = 25
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  hex_display_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last_owner;

  logic       found;
  logic [1:0] winner;
  logic [1:0] cand;
  logic [3:0] win_nib;
  logic [3:0] own_nib;
  logic       release_ev;

  // Active-low segment pattern, bit 0 = segment a.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h67; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return ~s;
  endfunction

  // Search starts one past the previous owner and wraps once, so the
  // previous owner is only re-picked when it is the sole requester.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    found  = 1'b0;
    winner = last_owner;
    cand   = last_owner;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner + 2'(k);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign win_nib    = bus.data[{winner, 2'b00} +: 4];
  assign own_nib    = bus.data[{last_owner, 2'b00} +: 4];
  assign release_ev = (cnt == '0) || !bus.req[last_owner];

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus.grant     <= 4'b0000;
      bus.busy      <= 1'b0;
      bus.cur_digit <= 4'h0;
      bus.hex_digit <= 7'h7F;
      bus.hex_owner <= 7'h7F;
      cnt           <= '0;
      last_owner    <= 2'd3;
    end else if (state == ST_IDLE || release_ev) begin
      if (found) begin
        state         <= ST_HOLD;
        bus.grant     <= 4'b0001 << winner;
        bus.busy      <= 1'b1;
        bus.cur_digit <= win_nib;
        bus.hex_digit <= seg7(win_nib);
        bus.hex_owner <= seg7({2'b00, winner});
        cnt           <= CNT_W'(HOLD_CYCLES - 1);
        last_owner    <= winner;
      end else begin
        state         <= ST_IDLE;
        bus.grant     <= 4'b0000;
        bus.busy      <= 1'b0;
        bus.cur_digit <= 4'h0;
        bus.hex_digit <= 7'h7F;
        bus.hex_owner <= 7'h7F;
      end
    end else begin
      // Holding: owner keeps the display and its nibble updates live.
      cnt           <= cnt - 1'b1;
      bus.cur_digit <= own_nib;
      bus.hex_digit <= seg7(own_nib);
    end
  end

endmodule
